// File: rtl/rr_req_arbiter_pkg.sv
// Shared definitions for the rotating-priority request arbiter:
// FSM state encoding, grant index type and the default hold limit.
package rr_req_arbiter_pkg;

   // Two-bit requester index, {i0,i1} on the decoder side
   typedef logic [1:0] idx_t;

   // FSM state encoding, kept as plain constants for legacy tools
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Default number of consecutive grant cycles before a forced release
   localparam int unsigned MAX_HOLD_DEF = 8;

   // Pointer value after releasing requester 'idx'; wraps 3 -> 0
   function automatic idx_t next_ptr(input idx_t idx);
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/rr_req_arbiter_pick.sv
// Combinational rotating-priority selector: returns the first set request
// bit found when searching upward from ptr, modulo 4.
module rr_priority_pick
   import rr_req_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [1:0] index,
   output logic       any
);

   idx_t cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins
   always_comb begin
      index = '0;
      any   = 1'b0;
      cand  = '0;
      for (int i = 3; i >= 0; i--) begin
         cand = ptr + 2'(i);
         if (req[cand]) begin
            index = cand;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_req_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Grants are presented as Enable plus a 2-bit index {i0,i1} that drive a
// 2-to-4 decoder directly. Every grant is followed by at least one idle
// cycle; a grant that runs out its hold budget raises a one-cycle timeout.
module rr_req_arbiter
   import rr_req_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic       Enable,
   output logic       i0,
   output logic       i1,
   output logic       timeout
);

   // Hold count value seen during the last permitted grant cycle
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [0:0] state;
   idx_t       ptr;
   idx_t       idx;
   logic [7:0] hold;

   logic [1:0] pick_idx;
   logic       pick_any;
   logic       hold_expire;
   logic       grantee_req;
   logic       release_now;

   rr_priority_pick u_pick (
      .req   (req),
      .ptr   (ptr),
      .index (pick_idx),
      .any   (pick_any)
   );

   // Release terms for the current grant; timeout only when the hold limit
   // is the sole reason for letting go
   always_comb begin
      grantee_req = req[idx];
      hold_expire = (hold == HOLD_LAST);
      release_now = done | ~grantee_req | hold_expire;
   end

   // Arbitration FSM with registered grant outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         idx     <= '0;
         hold    <= '0;
         Enable  <= 1'b0;
         timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               timeout <= 1'b0;
               if (pick_any) begin
                  state  <= ST_GRANT;
                  idx    <= pick_idx;
                  hold   <= '0;
                  Enable <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  state   <= ST_IDLE;
                  idx     <= '0;
                  hold    <= '0;
                  Enable  <= 1'b0;
                  ptr     <= next_ptr(idx);
                  timeout <= hold_expire & ~done & grantee_req;
               end else if (hold != 8'hFF) begin
                  hold <= hold + 8'd1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               idx     <= '0;
               hold    <= '0;
               Enable  <= 1'b0;
               timeout <= 1'b0;
            end
         endcase
      end
   end

   assign i0 = idx[1];
   assign i1 = idx[0];

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed bench for rr_req_arbiter: grant outputs feed a 2-to-4 decoder
// model and both are compared against hand-computed values each cycle.
module tb_rr_req_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic       done;
   logic       Enable;
   logic       i0;
   logic       i1;
   logic       timeout;
   logic       d0, d1, d2, d3;

   int checks;
   int errors;

   rr_req_arbiter #(.MAX_HOLD(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .done    (done),
      .Enable  (Enable),
      .i0      (i0),
      .i1      (i1),
      .timeout (timeout)
   );

   // 2-to-4 decoder driven by the grant outputs
   assign d0 = Enable & ~i0 & ~i1;
   assign d1 = Enable & ~i0 &  i1;
   assign d2 = Enable &  i0 & ~i1;
   assign d3 = Enable &  i0 &  i1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic exp_en,
                      input logic [1:0] exp_idx, input logic exp_to);
      logic [3:0] exp_dec;
      exp_dec = exp_en ? (4'b0001 << exp_idx) : 4'b0000;
      checks++;
      assert (Enable === exp_en) else begin
         errors++;
         $error("FAIL %s Enable got %0b want %0b", tag, Enable, exp_en);
      end
      checks++;
      assert ({i0, i1} === exp_idx) else begin
         errors++;
         $error("FAIL %s index got %0d want %0d", tag, {i0, i1}, exp_idx);
      end
      checks++;
      assert (timeout === exp_to) else begin
         errors++;
         $error("FAIL %s timeout got %0b want %0b", tag, timeout, exp_to);
      end
      checks++;
      assert ({d3, d2, d1, d0} === exp_dec) else begin
         errors++;
         $error("FAIL %s decoder got %b want %b", tag, {d3, d2, d1, d0}, exp_dec);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      req    = 4'b0000;
      done   = 1'b0;

      // Reset state
      tick(); chk("reset0", 1'b0, 2'd0, 1'b0);
      tick(); chk("reset1", 1'b0, 2'd0, 1'b0);

      // Alternating grants 0,2,0,2 with idle gaps
      reset = 1'b0; req = 4'b0101;
      tick(); chk("alt_g0a", 1'b1, 2'd0, 1'b0);
      done = 1'b1; tick(); chk("alt_gap1", 1'b0, 2'd0, 1'b0);
      done = 1'b0; tick(); chk("alt_g2a", 1'b1, 2'd2, 1'b0);
      done = 1'b1; tick(); chk("alt_gap2", 1'b0, 2'd0, 1'b0);
      done = 1'b0; tick(); chk("alt_g0b", 1'b1, 2'd0, 1'b0);
      done = 1'b1; tick(); chk("alt_gap3", 1'b0, 2'd0, 1'b0);
      done = 1'b0; tick(); chk("alt_g2b", 1'b1, 2'd2, 1'b0);
      done = 1'b1; tick(); chk("alt_gap4", 1'b0, 2'd0, 1'b0);

      // ptr is 3: grant 3, then wrap to 0, then back to 3
      done = 1'b0; req = 4'b1000;
      tick(); chk("wrap_g3", 1'b1, 2'd3, 1'b0);
      req = 4'b1001; done = 1'b1;
      tick(); chk("wrap_gap", 1'b0, 2'd0, 1'b0);
      done = 1'b0;
      tick(); chk("wrap_g0", 1'b1, 2'd0, 1'b0);
      done = 1'b1;
      tick(); chk("wrap_gap2", 1'b0, 2'd0, 1'b0);
      done = 1'b0;
      tick(); chk("wrap_g3b", 1'b1, 2'd3, 1'b0);
      // Other lines changing during a grant do not disturb it
      req = 4'b1011;
      tick(); chk("nogrant_chg", 1'b1, 2'd3, 1'b0);
      // Dropping the granted request releases without timeout
      req = 4'b0000;
      tick(); chk("reqdrop", 1'b0, 2'd0, 1'b0);

      // Hold limit: ptr is 0, requester 1 holds for 8 cycles then times out
      req = 4'b0010;
      tick(); chk("hold_c1", 1'b1, 2'd1, 1'b0);
      for (int k = 2; k <= 8; k++) begin
         tick(); chk($sformatf("hold_c%0d", k), 1'b1, 2'd1, 1'b0);
      end
      tick(); chk("hold_timeout", 1'b0, 2'd0, 1'b1);
      tick(); chk("hold_regrant", 1'b1, 2'd1, 1'b0);

      // done on the 8th grant cycle: normal release, no timeout
      for (int k = 2; k <= 8; k++) begin
         tick(); chk($sformatf("d8_c%0d", k), 1'b1, 2'd1, 1'b0);
      end
      done = 1'b1;
      tick(); chk("d8_release", 1'b0, 2'd0, 1'b0);
      done = 1'b0; req = 4'b0000;
      tick(); chk("d8_idle", 1'b0, 2'd0, 1'b0);

      // done while idle is ignored
      done = 1'b1;
      tick(); chk("idle_done", 1'b0, 2'd0, 1'b0);
      done = 1'b0;

      // Reset during the 3rd cycle of a grant to requester 2
      req = 4'b0100;
      tick(); chk("rst_c1", 1'b1, 2'd2, 1'b0);
      tick(); chk("rst_c2", 1'b1, 2'd2, 1'b0);
      tick(); chk("rst_c3", 1'b1, 2'd2, 1'b0);
      reset = 1'b1;
      tick(); chk("rst_drop", 1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      tick(); chk("rst_regrant", 1'b1, 2'd2, 1'b0);
      done = 1'b1;
      tick(); chk("rst_release", 1'b0, 2'd0, 1'b0);

      // First arbitration after reset starts at requester 0
      done = 1'b0; reset = 1'b1; req = 4'b1111;
      tick(); chk("post_rst", 1'b0, 2'd0, 1'b0);
      reset = 1'b0;
      tick(); chk("post_rst_g0", 1'b1, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_req_arbiter.md
RR_REQ_ARBITER -- requirements
Module: rr_req_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum consecutive grant cycles before forced release (legal range 2..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request lines; req[n] high = requester n wants the shared resource.
REQ-005 Port: done  input  1  current grantee finished; sampled only in GRANT.
REQ-006 Port: Enable  output  1  grant valid; drives decoder Enable directly.
REQ-007 Port: i0  output  1  grant index MSB; drives decoder i0.
REQ-008 Port: i1  output  1  grant index LSB; drives decoder i1; granted requester n = {i0,i1}.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE and GRANT; all outputs registered.
REQ-011 In IDLE, Enable, i0, i1 and timeout SHALL be 0.
REQ-012 In IDLE with req != 0, the block SHALL select the first set req bit searching upward from pointer ptr (mod 4), and enter GRANT on the next edge.
REQ-013 Latency: req sampled in IDLE -> Enable=1 with index on {i0,i1} exactly 1 cycle later.
REQ-014 In GRANT, {i0,i1} SHALL remain stable for the whole grant.
REQ-015 Release SHALL occur on the first edge where done=1, or req[index]=0, or hold count reaches MAX_HOLD.
REQ-016 Hold count SHALL clear on grant entry, increment each GRANT cycle, saturate; Enable high for at most MAX_HOLD cycles per grant.
REQ-017 On release the FSM SHALL return to IDLE for at least one cycle (Enable=0 gap), even if other requests are pending.
REQ-018 On release, ptr SHALL become (index+1) mod 4; wrap 3 -> 0.
REQ-019 timeout SHALL pulse for exactly one cycle, coincident with the IDLE gap cycle, only when release is due solely to MAX_HOLD.
REQ-020 If done=1 or req drop coincides with MAX_HOLD expiry, release SHALL be normal and timeout SHALL stay 0.
REQ-021 Request changes on non-granted lines during GRANT SHALL have no effect until next IDLE.
REQ-022 done asserted in IDLE SHALL be ignored.

Reset
REQ-023 While reset=1 on an edge: state=IDLE, ptr=0, hold count=0, Enable=0, i0=0, i1=0, timeout=0.
REQ-024 Reset asserted mid-grant SHALL drop Enable on the following edge with no timeout pulse and no ptr advance.
REQ-025 First arbitration after reset SHALL start search at requester 0.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the 2-bit index type and the MAX_HOLD default.
REQ-027 Rotating-priority selection SHALL be a separate combinational sub-module rr_priority_pick (inputs req, ptr; outputs index, any).
REQ-028 The block SHALL instantiate the existing 2-to-4 decoder only in the bench, not internally.

Verification
REQ-029 Bench SHALL connect Enable/i0/i1 to the team decoder and check one-hot d0..d3 equals granted index every cycle; all-zero when Enable=0.
REQ-030 Reset, then req=4'b0101 held, done pulsed each grant -> grants 0, 2, 0, 2 with one-cycle gaps between.
REQ-031 ptr=3 (after grant to 3), req=4'b1001 -> next grant index 0 (wrap), then 3.
REQ-032 req=4'b0010 held, done=0, MAX_HOLD=8 -> Enable high exactly 8 cycles, timeout=1 for one cycle, Enable=0, then regrant index 1.
REQ-033 done=1 on the 8th grant cycle with MAX_HOLD=8 -> release, timeout stays 0.
REQ-034 Reset asserted on 3rd cycle of grant to index 2 -> next cycle Enable=0, i0=i1=0; with req=4'b0100 still held, regrant index 2 one cycle after reset drops.
